// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the DDS generator and the sine frequency meter.
//   meter_state_t : hysteresis crossing-detector states
//   DDS_DATA_W    : default sine sample width (unsigned offset binary)
//   MID_SCALE     : mid-scale code for the default sample width
package dds_pkg;

  localparam int unsigned DDS_DATA_W = 9;
  localparam int unsigned MID_SCALE  = 1 << (DDS_DATA_W - 1);

  typedef enum logic [1:0] {
    FIRST_LO,
    FIRST_HI,
    RUN_LO,
    RUN_HI
  } meter_state_t;

endpackage

// File: rtl/sine_xing_detect.sv
// sine_xing_detect: rising mid-scale crossing detector with hysteresis.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_sample_in      : sine sample (offset binary)
//   i_sample_valid   : sample is valid; invalid cycles hold state
//   i_restart        : force re-acquisition (back to FIRST_LO) on the next edge
//   o_xing           : this valid sample is a rising crossing (combinational)
//   o_first          : detector is waiting for the reference crossing
//   o_run            : detector is in a RUN_* state
module sine_xing_detect
  import dds_pkg::*;
#(
  parameter int unsigned DATA_W = DDS_DATA_W,
  parameter int unsigned HYST   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_sample_in,
  input  logic              i_sample_valid,
  input  logic              i_restart,
  output logic              o_xing,
  output logic              o_first,
  output logic              o_run
);

  localparam int unsigned       MID = 1 << (DATA_W - 1);
  localparam logic [DATA_W-1:0] LO  = DATA_W'(MID - HYST);
  localparam logic [DATA_W-1:0] HI  = DATA_W'(MID + HYST);

  meter_state_t r_state;
  meter_state_t w_state_next;
  logic         w_below;
  logic         w_above;

  assign w_below = i_sample_in < LO;
  assign w_above = i_sample_in >= HI;

  // Outputs kept apart from the next-state logic: i_restart is derived from o_xing
  // in the parent, so mixing them would form a false combinational loop.
  always_comb begin
    o_first = (r_state == FIRST_HI);
    o_run   = (r_state == RUN_LO) || (r_state == RUN_HI);
    o_xing  = i_sample_valid && w_above && ((r_state == FIRST_HI) || (r_state == RUN_HI));
  end

  always_comb begin
    w_state_next = r_state;
    if (i_sample_valid) begin
      unique case (r_state)
        FIRST_LO: if (w_below) w_state_next = FIRST_HI;
        FIRST_HI: if (w_above) w_state_next = RUN_LO;
        RUN_LO:   if (w_below) w_state_next = RUN_HI;
        RUN_HI:   if (w_above) w_state_next = RUN_LO;
        default:  w_state_next = FIRST_LO;
      endcase
    end
    if (i_restart) w_state_next = FIRST_LO;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= FIRST_LO;
    else       r_state <= w_state_next;
  end

endmodule

// File: rtl/sine_freq_meter.sv
// sine_freq_meter: average period (in valid samples) over 2^AVG_LOG2 periods of a sine,
// plus peak and trough over the same window; pulses timeout on loss of signal.
//   clk, rst      : clock, synchronous active-high reset
//   sample_in     : sine sample (offset binary), sample_valid qualifies it
//   period_out    : average period, truncated; peak_out / trough_out : window max / min
//   meas_valid    : one-cycle pulse when the three results update
//   timeout       : one-cycle pulse when TIMEOUT valid samples pass without a crossing
module sine_freq_meter
  import dds_pkg::*;
#(
  parameter int unsigned DATA_W   = DDS_DATA_W,
  parameter int unsigned HYST     = 16,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned TIMEOUT  = (2 ** CNT_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [CNT_W-1:0]  period_out,
  output logic [DATA_W-1:0] peak_out,
  output logic [DATA_W-1:0] trough_out,
  output logic              meas_valid,
  output logic              timeout
);

  localparam int unsigned       ACC_W  = CNT_W + AVG_LOG2;
  localparam int unsigned       NI_W   = AVG_LOG2 + 1;
  localparam logic [NI_W-1:0]   NWIN   = NI_W'(1 << AVG_LOG2);
  localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);

  logic              w_xing, w_first, w_run, w_restart;

  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [CNT_W-1:0]  r_idle, w_idle_d;
  logic [ACC_W-1:0]  r_acc, w_acc_d;
  logic [NI_W-1:0]   r_nint, w_nint_d;
  logic [DATA_W-1:0] r_max, w_max_d, r_min, w_min_d;
  logic [CNT_W-1:0]  r_period, w_period_d;
  logic [DATA_W-1:0] r_peak, w_peak_d, r_trough, w_trough_d;
  logic              r_meas_valid, w_meas_valid_d, r_timeout, w_timeout_d;

  logic [ACC_W-1:0]  w_acc_sum;
  logic [NI_W-1:0]   w_nint_inc;
  logic [CNT_W-1:0]  w_cnt_inc, w_idle_inc;
  logic [DATA_W-1:0] w_max_upd, w_min_upd;

  sine_xing_detect #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_xing (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample_in    (sample_in),
    .i_sample_valid (sample_valid),
    .i_restart      (w_restart),
    .o_xing         (w_xing),
    .o_first        (w_first),
    .o_run          (w_run)
  );

  // Interval length is cnt+1: cnt excludes the crossing sample itself.
  assign w_acc_sum  = r_acc + ACC_W'(r_cnt) + ACC_W'(1);
  assign w_nint_inc = r_nint + NI_W'(1);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_idle_inc = r_idle + CNT_W'(1);
  assign w_max_upd  = (sample_in > r_max) ? sample_in : r_max;
  assign w_min_upd  = (sample_in < r_min) ? sample_in : r_min;

  always_comb begin
    w_cnt_d        = r_cnt;
    w_idle_d       = r_idle;
    w_acc_d        = r_acc;
    w_nint_d       = r_nint;
    w_max_d        = r_max;
    w_min_d        = r_min;
    w_period_d     = r_period;
    w_peak_d       = r_peak;
    w_trough_d     = r_trough;
    w_meas_valid_d = 1'b0;
    w_timeout_d    = 1'b0;
    w_restart      = 1'b0;
    if (sample_valid) begin
      if (w_xing && w_first) begin
        // Reference crossing: open the first window.
        w_cnt_d  = '0;
        w_idle_d = '0;
        w_acc_d  = '0;
        w_nint_d = '0;
        w_max_d  = sample_in;
        w_min_d  = sample_in;
      end else if (w_run) begin
        w_max_d = w_max_upd;
        w_min_d = w_min_upd;
        if (w_xing) begin
          w_cnt_d = '0;
          if (w_nint_inc == NWIN) begin
            w_period_d     = CNT_W'(w_acc_sum >> AVG_LOG2);
            w_peak_d       = w_max_upd;
            w_trough_d     = w_min_upd;
            w_meas_valid_d = 1'b1;
            w_acc_d        = '0;
            w_nint_d       = '0;
            // The closing crossing also opens the next window.
            w_max_d        = sample_in;
            w_min_d        = sample_in;
          end else begin
            w_acc_d  = w_acc_sum;
            w_nint_d = w_nint_inc;
          end
        end else if (w_cnt_inc == TO_VAL) begin
          w_timeout_d = 1'b1;
          w_restart   = 1'b1;
          w_cnt_d     = '0;
          w_acc_d     = '0;
          w_nint_d    = '0;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end else begin
        if (w_idle_inc == TO_VAL) begin
          w_timeout_d = 1'b1;
          w_restart   = 1'b1;
          w_idle_d    = '0;
          w_cnt_d     = '0;
          w_acc_d     = '0;
          w_nint_d    = '0;
        end else begin
          w_idle_d = w_idle_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idle       <= '0;
      r_acc        <= '0;
      r_nint       <= '0;
      r_max        <= '0;
      r_min        <= '0;
      r_period     <= '0;
      r_peak       <= '0;
      r_trough     <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_d;
      r_idle       <= w_idle_d;
      r_acc        <= w_acc_d;
      r_nint       <= w_nint_d;
      r_max        <= w_max_d;
      r_min        <= w_min_d;
      r_period     <= w_period_d;
      r_peak       <= w_peak_d;
      r_trough     <= w_trough_d;
      r_meas_valid <= w_meas_valid_d;
      r_timeout    <= w_timeout_d;
    end
  end

  assign period_out = r_period;
  assign peak_out   = r_peak;
  assign trough_out = r_trough;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_sine_freq_meter.sv
// tb_sine_freq_meter: directed bench for sine_freq_meter (TIMEOUT shortened to 1000).
module tb_sine_freq_meter;

  logic        clk;
  logic        rst;
  logic [8:0]  sample_in;
  logic        sample_valid;
  logic [19:0] period_out;
  logic [8:0]  peak_out;
  logic [8:0]  trough_out;
  logic        meas_valid;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int n_meas, n_to;
  int meas_cyc [16];
  int per_log  [16];
  int to_cyc   [16];
  int t0;

  sine_freq_meter #(
    .DATA_W   (9),
    .HYST     (16),
    .AVG_LOG2 (2),
    .CNT_W    (20),
    .TIMEOUT  (1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .period_out   (period_out),
    .peak_out     (peak_out),
    .trough_out   (trough_out),
    .meas_valid   (meas_valid),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Event log, sampled on the falling edge away from output updates.
  always @(negedge clk) begin
    if (meas_valid) begin
      if (n_meas < 16) begin
        meas_cyc[n_meas] = cyc;
        per_log[n_meas]  = int'(period_out);
      end
      n_meas++;
    end
    if (timeout) begin
      if (n_to < 16) to_cyc[n_to] = cyc;
      n_to++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic put(input logic [8:0] v, input logic vld);
    sample_in    = v;
    sample_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    n_meas = 0;
    n_to   = 0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
  endtask

  function automatic logic [8:0] tri_val(input int per, input int ph);
    int half;
    half = per / 2;
    if (ph < half) return 9'(56 + (400 * ph) / half);
    return 9'(456 - (400 * (ph - half)) / half);
  endfunction

  // nper triangle periods; each valid sample followed by gap invalid cycles.
  task automatic tri_run(input int per, input int nper, input int gap);
    for (int p = 0; p < nper; p++) begin
      for (int ph = 0; ph < per; ph++) begin
        put(tri_val(per, ph), 1'b1);
        for (int g = 0; g < gap; g++) put(tri_val(per, ph), 1'b0);
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    clear_log();
    @(posedge clk);
    #1;

    // Reset state
    rst = 1'b1;
    put(9'd300, 1'b1);
    rst = 1'b0;
    clear_log();
    check_eq("rst_period", 32'(period_out), 0);
    check_eq("rst_peak", 32'(peak_out), 0);
    check_eq("rst_trough", 32'(trough_out), 0);
    check_eq("rst_meas", 32'(meas_valid), 0);
    check_eq("rst_timeout", 32'(timeout), 0);

    // Continuous triangle, period 40: ref crossing at sample 11, 5th at 171
    do_reset();
    t0 = cyc;
    tri_run(40, 10, 0);
    check_eq("tri_nmeas", 32'(n_meas), 2);
    check_eq("tri_first_lat", 32'(meas_cyc[0] - t0), 172);
    check_eq("tri_spacing", 32'(meas_cyc[1] - meas_cyc[0]), 160);
    check_eq("tri_period", 32'(period_out), 40);
    check_eq("tri_peak", 32'(peak_out), 456);
    check_eq("tri_trough", 32'(trough_out), 56);
    check_eq("tri_nto", 32'(n_to), 0);

    // Loss of signal in RUN: 28 samples after last crossing, then flat mid-scale
    t0 = cyc;
    for (int i = 0; i < 1200; i++) put(9'd256, 1'b1);
    check_eq("run_to_count", 32'(n_to), 1);
    check_eq("run_to_lat", 32'(to_cyc[0] - t0), 972);
    check_eq("run_to_hold_period", 32'(period_out), 40);
    check_eq("run_to_hold_peak", 32'(peak_out), 456);

    // Sparse valid, 1 cycle in 3
    do_reset();
    tri_run(40, 10, 2);
    check_eq("gap_nmeas", 32'(n_meas), 2);
    check_eq("gap_spacing", 32'(meas_cyc[1] - meas_cyc[0]), 480);
    check_eq("gap_period", 32'(period_out), 40);

    // Chatter inside hysteresis band: only idle timeouts
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 2500; i++) put((i % 2 == 0) ? 9'd250 : 9'd262, 1'b1);
    check_eq("chat_nmeas", 32'(n_meas), 0);
    check_eq("chat_nto", 32'(n_to), 2);
    check_eq("chat_to_lat", 32'(to_cyc[0] - t0), 1000);
    check_eq("chat_to_spacing", 32'(to_cyc[1] - to_cyc[0]), 1000);

    // Period switch: intervals 40x6, 46 (29+17), 60x5 -> windows 40, 46, 60
    do_reset();
    tri_run(40, 7, 0);
    tri_run(60, 6, 0);
    check_eq("sw_nmeas", 32'(n_meas), 3);
    check_eq("sw_w0", 32'(per_log[0]), 40);
    check_eq("sw_w1", 32'(per_log[1]), 46);
    check_eq("sw_w2", 32'(per_log[2]), 60);

    // Reset mid-window, then 5 fresh crossings needed
    do_reset();
    tri_run(40, 12, 0);
    check_eq("mid_pre_period", 32'(period_out), 40);
    do_reset();
    check_eq("mid_rst_period", 32'(period_out), 0);
    check_eq("mid_rst_peak", 32'(peak_out), 0);
    check_eq("mid_rst_trough", 32'(trough_out), 0);
    tri_run(40, 4, 0);
    check_eq("mid_4xing_nmeas", 32'(n_meas), 0);
    tri_run(40, 1, 0);
    check_eq("mid_5xing_nmeas", 32'(n_meas), 1);
    check_eq("mid_5xing_period", 32'(period_out), 40);

    // DDS loopback: 512-entry sine, step 8 -> 64 samples per period
    do_reset();
    for (int i = 0; i < 20 * 64; i++) begin
      real r;
      int  a;
      a = (i * 8) % 512;
      r = 200.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 512.0);
      put(9'(256 + ((r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r))), 1'b1);
    end
    check_eq("dds_nmeas", 32'(n_meas), 4);
    for (int w = 0; w < 4; w++) check_eq($sformatf("dds_period_w%0d", w), 32'(per_log[w]), 64);
    check_eq("dds_peak", 32'(peak_out), 456);
    check_eq("dds_trough", 32'(trough_out), 56);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sine_freq_meter.md
# sine_freq_meter

Measurement end of the DDS sine path. It takes the 9-bit offset-binary sine samples produced by the DDS/sine-ROM chain, detects rising mid-scale crossings with hysteresis, and reports the average period in samples over a window of periods, plus peak and trough amplitude. It is used in the DDS test module as a loopback checker, and as the front end of frequency-tuning calibration.

## Interface
- DATA_W, 9, sample width (unsigned offset binary, mid-scale = 2^(DATA_W-1) = 256)
- HYST, 16, hysteresis half-width in LSBs around mid-scale
- AVG_LOG2, 2, window = 2^AVG_LOG2 periods (default 4)
- CNT_W, 20, period counter width
- TIMEOUT, 2^CNT_W-1, sample count without a crossing before timeout fires
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset
- sample_in  input  DATA_W  sine sample
- sample_valid  input  1  sample_in is valid this cycle; may have gaps
- period_out  output  CNT_W  average period in valid samples, truncated
- peak_out  output  DATA_W  maximum sample over the last completed window
- trough_out  output  DATA_W  minimum sample over the last completed window
- meas_valid  output  1  one-cycle pulse when the three outputs above update
- timeout  output  1  one-cycle pulse on loss of signal

## Operation
- Thresholds:
  - LO = MID-HYST (240)
  - HI = MID+HYST (272)
- Only cycles with sample_valid=1 are processed. All other cycles hold all state.
- FSM states:
  - FIRST_LO: wait for sample < LO, then go to FIRST_HI.
  - FIRST_HI: wait for sample >= HI. That sample is the reference crossing.
    - Clear cnt, acc, and the interval count.
    - Load the peak and trough trackers with this sample.
    - Go to RUN_LO.
  - RUN_LO: wait for sample < LO, then go to RUN_HI.
  - RUN_HI: wait for sample >= HI. That sample is a crossing.
    - Add cnt+1 to acc and increment the interval count.
    - Restart cnt at 0.
    - Stay in RUN_* by going to RUN_LO.
- cnt:
  - Increments on every valid sample in the RUN states that is not a crossing.
  - Interval length = valid samples after the previous crossing, up to and including this crossing.
- Window completion: when the interval count reaches 2^AVG_LOG2 intervals:
  - period_out = acc >> AVG_LOG2. acc is CNT_W+AVG_LOG2 bits wide, so it cannot overflow.
  - peak_out and trough_out are loaded from the trackers, including the current sample.
  - meas_valid pulses.
  - acc and the interval count clear. Trackers restart from the current sample.
  - The crossing sample also starts the next window. Windows are back to back, with no re-acquisition.
- Trackers: on every valid sample in the RUN states, max/min update with sample_in.
- Timeout:
  - Fires if cnt reaches TIMEOUT in any RUN state. In FIRST_* states, a separate idle count of valid samples reaches TIMEOUT.
  - Action: pulse timeout, go to FIRST_LO, clear acc, cnt, and the interval count.
  - Held outputs keep their last values.
- Boundaries:
  - A sample between LO and HI never changes state. Chatter within ±HYST produces no crossings.
  - A sample < LO seen in RUN_HI is ignored.
  - A crossing and a timeout on the same sample: the crossing wins, no timeout.
- rst, at any time including mid-window:
  - State goes to FIRST_LO.
  - All counters, acc, period_out, peak_out, trough_out, meas_valid and timeout go to 0.

## Timing
- Outputs are registered.
- meas_valid and timeout assert on the cycle after the valid sample that caused them.
- period_out, peak_out and trough_out change in that same cycle and hold until the next meas_valid.
- First meas_valid comes one cycle after the (2^AVG_LOG2+1)-th crossing following reset, counting the reference crossing.
- Throughput: one sample per clk. sample_valid may be high every cycle.
- No backpressure. The block never stalls its input.

## Structure
- dds_pkg (shared with the DDS generator) holds:
  - meter_state_t enum {FIRST_LO, FIRST_HI, RUN_LO, RUN_HI}
  - MID_SCALE
  - the default DATA_W
- Sub-module sine_xing_detect:
  - Contains the hysteresis FSM.
  - Inputs: sample_in, sample_valid, a restart input.
  - Outputs: the crossing pulse and a "first" flag.
- sine_freq_meter keeps the counter, accumulator, trackers and timeout logic.

## Test plan
- Triangle wave 56→456→56 with period 40 samples, sample_valid=1 continuously -> meas_valid every 160 samples; period_out=40, peak_out=456, trough_out=56.
- DDS loopback: generator with 9-bit address, step 8 (64 samples per period) -> period_out=64 ±0 on every window after the first.
- Same triangle with sample_valid high 1 cycle in 3 -> period_out=40; meas_valid spacing 480 clk.
- Input oscillating 250↔262, with TIMEOUT set to 1000 for the test -> no meas_valid; timeout pulse after 1000 valid samples, then repeats every 1000.
- Period switch: 4 periods of 40 then periods of 60 -> window containing the switch gives (40·k+60·(4-k))/4 truncated; the following window gives 60.
- rst asserted for 1 cycle mid-window -> all outputs 0 next cycle; next meas_valid only after 5 fresh crossings.
